serial_addsub_alu: RTL and testbench

Parametrised multi-cycle add/subtract unit, successor to the combinational 6-bit carry adder in the ALU directory.
- Processes DIGIT bits per clock, LSB chunk first, trading latency for ripple depth.
- Keeps the existing 4-bit instruction encoding (4'b1011 = A-B) and adds ADD, CMP, status flags and a start/done handshake.
- Sits between the ALU decode stage and the register-file write-back.

---
 rtl/serial_addsub_alu.sv | 172 +++++++++++++++++
 tb/tb_serial_addsub_alu.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_alu.sv
// serial_addsub_alu: multi-cycle add/subtract/compare unit.
// Operands are consumed DIGIT bits per clock, least significant chunk first,
// so the carry chain per cycle is only DIGIT bits deep. A start/done
// handshake brackets each operation; X and the status flags are registers
// that hold until the next completion or reset.
module serial_addsub_alu #(
  parameter int WIDTH = 6,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       instruction,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] X,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             op_err
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [3:0] OP_ADD = 4'b1010;
  localparam logic [3:0] OP_SUB = 4'b1011;
  localparam logic [3:0] OP_CMP = 4'b1101;

  // A partial last chunk would need a different datapath; refuse to build.
  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_addsub_alu: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operand shift registers: the active chunk always sits in the low DIGIT bits.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;        // B for ADD, ~B for SUB/CMP
  logic             cy_q;       // running carry between chunks
  logic             cmp_q;      // compare: flags only, X untouched
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] res_sr;     // result chunks shifted in from the top

  logic             op_legal;
  logic             op_sub;
  logic [DIGIT:0]   chunk_sum;
  logic [WIDTH+DIGIT-1:0] res_wide;
  logic [WIDTH-1:0] res_nxt;
  logic             last_chunk;

  // One DIGIT-bit slice of the ripple adder, with carry-out in the top bit.
  function automatic logic [DIGIT:0] add_chunk(input logic [DIGIT-1:0] a,
                                               input logic [DIGIT-1:0] b,
                                               input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  endfunction

  assign op_legal = (instruction == OP_ADD) || (instruction == OP_SUB) ||
                    (instruction == OP_CMP);
  assign op_sub   = (instruction == OP_SUB) || (instruction == OP_CMP);
  assign busy     = (state != S_IDLE);

  // Datapath for the chunk handled on the coming edge.
  always_comb begin
    chunk_sum  = add_chunk(a_q[DIGIT-1:0], b_q[DIGIT-1:0], cy_q);
    res_wide   = {chunk_sum[DIGIT-1:0], res_sr};
    res_nxt    = res_wide[WIDTH+DIGIT-1:DIGIT];
    last_chunk = (cnt == CNT_W'(N - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: legal ops run N chunks, illegal ops report after one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = op_legal ? S_RUN : S_ERR;
        end
      end
      S_RUN: begin
        if (last_chunk) begin
          state_nxt = S_IDLE;
        end
      end
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latches, chunk accumulation and the visible result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      cy_q     <= 1'b0;
      cmp_q    <= 1'b0;
      cnt      <= '0;
      res_sr   <= '0;
      done     <= 1'b0;
      X        <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      op_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // An illegal opcode leaves every visible register alone until
          // it is reported; only legal ones clear the previous status.
          if (start && op_legal) begin
            a_q      <= A;
            b_q      <= op_sub ? ~B : B;
            cy_q     <= op_sub;
            cmp_q    <= (instruction == OP_CMP);
            cnt      <= '0;
            res_sr   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            op_err   <= 1'b0;
          end
        end
        S_RUN: begin
          a_q    <= a_q >> DIGIT;
          b_q    <= b_q >> DIGIT;
          cy_q   <= chunk_sum[DIGIT];
          res_sr <= res_nxt;
          cnt    <= cnt + 1'b1;
          if (last_chunk) begin
            if (!cmp_q) begin
              X <= res_nxt;
            end
            carry    <= chunk_sum[DIGIT];
            // On the last chunk the low slices of a_q/b_q hold the original
            // top bits, so bit DIGIT-1 is the operand sign.
            overflow <= (a_q[DIGIT-1] == b_q[DIGIT-1]) &&
                        (res_nxt[WIDTH-1] != a_q[DIGIT-1]);
            zero     <= (res_nxt == '0);
            done     <= 1'b1;
          end
        end
        S_ERR: begin
          op_err <= 1'b1;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_alu.sv
// Bench for serial_addsub_alu: a table of hand-computed vectors plus random
// operations through a scoreboard queue, hand-written sequences for busy
// re-start, mid-operation reset, and a DIGIT=1 instance for latency.
module tb_serial_addsub_alu;

  localparam logic [3:0] OP_ADD = 4'b1010;
  localparam logic [3:0] OP_SUB = 4'b1011;
  localparam logic [3:0] OP_CMP = 4'b1101;
  localparam int         LAT    = 3;

  typedef struct {
    logic [3:0] op;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] x;
    logic       c;
    logic       v;
    logic       z;
    logic       e;
  } vec_t;

  typedef struct {
    logic [5:0] x;
    logic       c;
    logic       v;
    logic       z;
    logic       e;
    int         lat;
    int         t_acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] instruction;
  logic [5:0] A, B, X;
  logic       busy, done, carry, overflow, zero, op_err;

  logic       start1;
  logic [3:0] instr1;
  logic [5:0] a1, b1, x1;
  logic       busy1, done1, carry1, ovf1, zero1, err1;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q[$];
  exp_t me;
  vec_t tbl[13];

  logic [5:0] mX;
  logic       mC, mV, mZ;

  serial_addsub_alu #(.WIDTH(6), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .instruction(instruction),
    .A(A), .B(B), .busy(busy), .done(done), .X(X), .carry(carry),
    .overflow(overflow), .zero(zero), .op_err(op_err)
  );

  serial_addsub_alu #(.WIDTH(6), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .instruction(instr1),
    .A(a1), .B(b1), .busy(busy1), .done(done1), .X(x1), .carry(carry1),
    .overflow(ovf1), .zero(zero1), .op_err(err1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic vec_t mkv(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b,
                               input logic [5:0] x, input logic c, input logic v,
                               input logic z, input logic e);
    vec_t r;
    r.op = op; r.a = a; r.b = b; r.x = x; r.c = c; r.v = v; r.z = z; r.e = e;
    return r;
  endfunction

  // Reference model using integer arithmetic on the current model state.
  function automatic exp_t model(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b);
    exp_t r;
    int   sa, sb, sr, ua, ub, ur;
    r.x = mX; r.c = mC; r.v = mV; r.z = mZ; r.e = 1'b1; r.lat = 1; r.t_acc = 0;
    if (op == OP_ADD || op == OP_SUB || op == OP_CMP) begin
      ua = int'(a); ub = int'(b);
      sa = (ua >= 32) ? ua - 64 : ua;
      sb = (ub >= 32) ? ub - 64 : ub;
      if (op == OP_ADD) begin
        sr = sa + sb; ur = ua + ub; r.c = (ur >= 64);
      end else begin
        sr = sa - sb; ur = ua - ub + 64; r.c = (ua >= ub);
      end
      ur  = ur % 64;
      r.v = (sr > 31) || (sr < -32);
      r.z = (ur == 0);
      r.e = 1'b0;
      if (op != OP_CMP) r.x = ur[5:0];
      r.lat = LAT;
    end
    return r;
  endfunction

  task automatic set_model(input exp_t e);
    mX = e.x; mC = e.c; mV = e.v; mZ = e.z;
  endtask

  task automatic issue(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b, input exp_t e);
    int w = 0;
    while (busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      checks++; errors++;
      $display("FAIL issue_timeout: busy still %0d after %0d cycles, required 0", busy, w);
    end
    instruction = op; A = a; B = b; start = 1'b1;
    e.t_acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d completions outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 with no operation outstanding, required 0");
      end else begin
        me = q.pop_front();
        chk("X", X, me.x);
        chk("carry", carry, me.c);
        chk("overflow", overflow, me.v);
        chk("zero", zero, me.z);
        chk("op_err", op_err, me.e);
        chk("busy_at_done", busy, 0);
        chk("latency", cyc - me.t_acc, me.lat);
      end
    end
  end

  initial begin
    exp_t e;
    logic [3:0] op;
    logic [5:0] ra, rb;
    int k, w;

    tbl[0]  = mkv(OP_SUB,  6'd4,  6'd1,  6'd3,  1'b1, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mkv(OP_SUB,  6'd57, 6'd7,  6'd50, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mkv(OP_ADD,  6'd31, 6'd1,  6'd32, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[3]  = mkv(OP_ADD,  6'd63, 6'd1,  6'd0,  1'b1, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mkv(OP_ADD,  6'd31, 6'd1,  6'd32, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mkv(OP_CMP,  6'd5,  6'd5,  6'd32, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[6]  = mkv(4'b0000, 6'd9,  6'd3,  6'd32, 1'b1, 1'b0, 1'b1, 1'b1);
    tbl[7]  = mkv(OP_SUB,  6'd0,  6'd1,  6'd63, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mkv(OP_CMP,  6'd32, 6'd1,  6'd63, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mkv(OP_ADD,  6'd32, 6'd32, 6'd0,  1'b1, 1'b1, 1'b1, 1'b0);
    tbl[10] = mkv(4'b1111, 6'd1,  6'd2,  6'd0,  1'b1, 1'b1, 1'b1, 1'b1);
    tbl[11] = mkv(OP_SUB,  6'd33, 6'd33, 6'd0,  1'b1, 1'b0, 1'b1, 1'b0);
    tbl[12] = mkv(OP_ADD,  6'd21, 6'd42, 6'd63, 1'b0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1; start = 1'b0; instruction = 4'b0; A = '0; B = '0;
    start1 = 1'b0; instr1 = 4'b0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_X", X, 0);
    chk("rst_carry", carry, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_zero", zero, 0);
    chk("rst_op_err", op_err, 0);
    rst = 1'b0;
    mX = '0; mC = 1'b0; mV = 1'b0; mZ = 1'b0;
    @(negedge clk);

    // Table vectors, issued back-to-back in each done cycle.
    for (int i = 0; i < 13; i++) begin
      e.x = tbl[i].x; e.c = tbl[i].c; e.v = tbl[i].v; e.z = tbl[i].z; e.e = tbl[i].e;
      e.lat = tbl[i].e ? 1 : LAT; e.t_acc = 0;
      issue(tbl[i].op, tbl[i].a, tbl[i].b, e);
      set_model(e);
    end
    drain();
    repeat (2) @(negedge clk);

    // start re-pulsed with other operands while busy: must be ignored.
    e = model(OP_SUB, 6'd10, 6'd3);
    issue(OP_SUB, 6'd10, 6'd3, e);
    set_model(e);
    instruction = OP_ADD; A = 6'd1; B = 6'd1; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("restart_ignored_idle", busy, 0);
    chk("restart_ignored_X", X, 7);

    // Reset at edge e2 of a running SUB discards it.
    e = model(OP_SUB, 6'd4, 6'd1);
    issue(OP_SUB, 6'd4, 6'd1, e);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    q.delete();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_X", X, 0);
    chk("midrst_carry", carry, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_zero", zero, 0);
    chk("midrst_op_err", op_err, 0);
    rst = 1'b0;
    mX = '0; mC = 1'b0; mV = 1'b0; mZ = 1'b0;
    e = model(OP_SUB, 6'd4, 6'd1);
    issue(OP_SUB, 6'd4, 6'd1, e);
    set_model(e);
    drain();
    repeat (4) @(negedge clk);

    // Random operations through the model.
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 3);
      if (k == 0)      op = OP_ADD;
      else if (k == 1) op = OP_SUB;
      else if (k == 2) op = OP_CMP;
      else begin
        op = 4'($urandom_range(0, 15));
        if (op == OP_ADD || op == OP_SUB || op == OP_CMP) op = 4'b0000;
      end
      ra = 6'($urandom);
      rb = 6'($urandom);
      e = model(op, ra, rb);
      issue(op, ra, rb, e);
      set_model(e);
    end
    drain();
    repeat (2) @(negedge clk);

    // DIGIT=1 build: same SUB, six-cycle latency.
    instr1 = OP_SUB; a1 = 6'd57; b1 = 6'd7; start1 = 1'b1;
    k = cyc;
    @(negedge clk);
    start1 = 1'b0;
    w = 0;
    while (!done1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("d1_done_seen", done1, 1);
    chk("d1_latency", cyc - (k + 1), 6);
    chk("d1_X", x1, 50);
    chk("d1_carry", carry1, 1);
    chk("d1_overflow", ovf1, 0);
    chk("d1_zero", zero1, 0);
    chk("d1_op_err", err1, 0);
    @(negedge clk);
    chk("d1_done_pulse", done1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
